mbgd_theta_update: RTL
======================

MBGD_THETA_UPDATE -- requirements
Module: mbgd_theta_update

Interface
REQ-001 Parameter DW, 8, element width of x, teta and h.
REQ-002 Parameter N, 8, number of features per sample.
REQ-003 Parameter BATCH_bit, 3, log2 of mini-batch size (BATCH = 8).
REQ-004 Parameter LR_SHIFT, 4, learning-rate right shift.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  global advance; low freezes all state.
REQ-008 load_teta  input  1  load teta_in and restart the batch.
REQ-009 teta_in  input  64  initial parameters; element i at bits [8i+7:8i], signed two's complement.
REQ-010 s_valid  input  1  sample present.
REQ-011 s_ready  output  1  sample accepted when s_valid and s_ready are both high at a clock edge.
REQ-012 x  input  64  features; element i at bits [8i+7:8i], unsigned.
REQ-013 h  input  8  hypothesis from the forward path, unsigned Q0.8 (0xFF represents 1.0).
REQ-014 y  input  1  label.
REQ-015 teta  output  64  current parameters, signed, same packing as teta_in.
REQ-016 upd_valid  output  1  one-cycle pulse when teta holds a newly updated value.

Function
REQ-017 The block SHALL use a two-state FSM:
- ACCUM: accepting samples.
- UPDATE: one cycle, no samples accepted.
REQ-018 s_ready SHALL be combinational: (state==ACCUM) && enable && !load_teta.
REQ-019 Per accepted sample, the block SHALL form the error e = {1'b0,h} - (y ? 255 : 0), 9-bit signed, range [-255, 255].
REQ-020 Per accepted sample, the block SHALL add e*x_i (17-bit signed) into acc_i for every i, using 20-bit signed accumulators, updated at the accepting edge.
REQ-021 A 3-bit sample counter SHALL increment on each accept.
- The accept that takes the count from 7 to wrap SHALL move the FSM to UPDATE.
REQ-022 In UPDATE, the block SHALL compute delta_i = acc_i >>> (DW + BATCH_bit + LR_SHIFT), an arithmetic shift that floors toward minus infinity.
REQ-023 In UPDATE, the block SHALL compute teta_i_new = teta_i - delta_i, saturated to [-128, 127].
REQ-024 On the edge ending UPDATE, the block SHALL:
- register teta_new;
- clear all acc_i and the counter;
- assert upd_valid for exactly that following cycle;
- return to ACCUM.
REQ-025 Latency: last sample accepted at edge k; new teta and upd_valid visible after edge k+1; s_ready may be high again from the cycle after edge k+1.
REQ-026 load_teta high with enable high SHALL take priority over everything, including UPDATE:
- teta <= teta_in;
- accumulators and counter cleared;
- state ACCUM;
- upd_valid 0;
- the concurrent sample is not accepted.
REQ-027 enable low SHALL hold all registers, including FSM state, counter, accumulators and teta. upd_valid SHALL be 0 while enable is low, and a pending UPDATE SHALL resume when enable returns high.
REQ-028 s_valid low in ACCUM SHALL leave the counter and accumulators unchanged.
- Gaps between samples SHALL be allowed.

Reset
REQ-029 Asserting resetn low SHALL immediately, without waiting for a clock edge, set:
- teta = 0;
- all acc_i = 0;
- counter = 0;
- state = ACCUM;
- upd_valid = 0.
REQ-030 Reset asserted mid-batch or during UPDATE SHALL discard the batch, with no partial update applied.
REQ-031 The first accept after reset release SHALL occur no earlier than the first rising edge with resetn high.

Verification
REQ-032 Zero error: load teta_in = 0x0505...05, then 8 samples x=0xFF.., h=0xFF, y=1 -> e=0, teta stays 0x05 per element, upd_valid one pulse one cycle after the 8th accept.
REQ-033 Positive gradient: teta 0, 8 samples x=0xFF.., h=0xFF, y=0 -> acc=520200, delta=15, teta = 0xF1 in every element.
REQ-034 Saturation: two cases.
- teta_in = 0x80.., stimulus as REQ-033 -> teta stays 0x80.
- teta_in = 0x7F.., x=0xFF.., h=0x00, y=1 (acc=-520200, delta=-16) -> teta stays 0x7F.
REQ-035 Stall: enable low for 3 cycles after the 4th accept, with s_valid held high -> s_ready low, no accepts, counter holds; exactly 8 accepts are still required before upd_valid.
REQ-036 Restart: load_teta with teta_in = 0x01.. after 3 accepts -> teta = 0x01.., those 3 samples discarded; the result after 8 more samples equals a fresh batch.
REQ-037 Reset in UPDATE: drop resetn in the cycle after the 8th accept -> teta = 0 and upd_valid = 0 immediately; no pulse after release.

Source files
------------

// File: rtl/mbgd_theta_update.sv
// Mini-batch gradient-descent parameter update.
// Accumulates err*x per feature over a mini-batch. At the end of the batch it
// spends one UPDATE cycle on the scaled step, then subtracts it from teta with
// saturation to the signed element range.
module mbgd_theta_update #(
  parameter int DW        = 8,
  parameter int N         = 8,
  parameter int BATCH_bit = 3,
  parameter int LR_SHIFT  = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enable,
  input  logic            load_teta,
  input  logic [N*DW-1:0] teta_in,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [N*DW-1:0] x,
  input  logic [DW-1:0]   h,
  input  logic            y,
  output logic [N*DW-1:0] teta,
  output logic            upd_valid
);

  // Accumulator holds BATCH products of (DW+1)-bit signed err by DW-bit unsigned x.
  localparam int AW = 2*DW + 1 + BATCH_bit;
  // Combined shift: Q0.DW hypothesis scale, batch average, learning rate.
  localparam int SH = DW + BATCH_bit + LR_SHIFT;

  localparam logic [0:0] ACCUM  = 1'b0;
  localparam logic [0:0] UPDATE = 1'b1;

  localparam logic signed [AW:0]        TETA_MAX = (AW+1)'((2**(DW-1)) - 1);
  localparam logic signed [AW:0]        TETA_MIN = (AW+1)'(-(2**(DW-1)));
  localparam logic [BATCH_bit-1:0]      CNT_LAST = '1;

  logic [0:0]            state_r;
  logic [BATCH_bit-1:0]  cnt_r;
  logic signed [AW-1:0]  acc_r [N];
  logic [N*DW-1:0]       teta_r;
  logic                  upd_valid_r;

  logic signed [DW:0]    err_s;
  logic signed [AW-1:0]  prod_s [N];
  logic signed [AW:0]    diff_s [N];
  logic [N*DW-1:0]       teta_new_s;
  logic                  accept_s;

  assign s_ready   = (state_r == ACCUM) && enable && !load_teta;
  assign accept_s  = s_ready && s_valid;
  assign teta      = teta_r;
  // The pulse is suppressed while the block is frozen.
  assign upd_valid = upd_valid_r && enable;

  // Error term and per-feature error*feature products for the current sample
  always_comb begin
    err_s = $signed({1'b0, h}) - (y ? $signed({1'b0, {DW{1'b1}}}) : $signed({(DW+1){1'b0}}));
    for (int i = 0; i < N; i++) begin
      prod_s[i] = AW'(err_s) * AW'($signed({1'b0, x[i*DW +: DW]}));
    end
  end

  // Scaled step (floor shift) subtracted from teta, saturated per element
  always_comb begin
    teta_new_s = teta_r;
    for (int i = 0; i < N; i++) begin
      diff_s[i] = (AW+1)'($signed(teta_r[i*DW +: DW])) - (AW+1)'(acc_r[i] >>> SH);
      if (diff_s[i] > TETA_MAX) begin
        teta_new_s[i*DW +: DW] = TETA_MAX[DW-1:0];
      end else if (diff_s[i] < TETA_MIN) begin
        teta_new_s[i*DW +: DW] = TETA_MIN[DW-1:0];
      end else begin
        teta_new_s[i*DW +: DW] = diff_s[i][DW-1:0];
      end
    end
  end

  // FSM, sample counter, accumulators, parameters and update pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ACCUM;
      cnt_r       <= '0;
      teta_r      <= '0;
      upd_valid_r <= 1'b0;
      for (int i = 0; i < N; i++) begin
        acc_r[i] <= '0;
      end
    end else if (enable) begin
      upd_valid_r <= 1'b0;
      if (load_teta) begin
        teta_r  <= teta_in;
        cnt_r   <= '0;
        state_r <= ACCUM;
        for (int i = 0; i < N; i++) begin
          acc_r[i] <= '0;
        end
      end else begin
        case (state_r)
          ACCUM: begin
            if (accept_s) begin
              for (int i = 0; i < N; i++) begin
                acc_r[i] <= acc_r[i] + prod_s[i];
              end
              cnt_r <= cnt_r + BATCH_bit'(1);
              if (cnt_r == CNT_LAST) begin
                state_r <= UPDATE;
              end else begin
                state_r <= ACCUM;
              end
            end else begin
              state_r <= ACCUM;
            end
          end
          UPDATE: begin
            teta_r      <= teta_new_s;
            cnt_r       <= '0;
            upd_valid_r <= 1'b1;
            state_r     <= ACCUM;
            for (int i = 0; i < N; i++) begin
              acc_r[i] <= '0;
            end
          end
          default: begin
            state_r <= ACCUM;
          end
        endcase
      end
    end else begin
      upd_valid_r <= 1'b0;
    end
  end

endmodule
